// File: rtl/output_controller.sv
// Per-output-port round-robin arbiter: grants one requesting input controller
// at a time and forwards its single-flit packet to the downstream FIFO/link.
module output_controller #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    N_REGISTER = 3,
  parameter int                    N_PORT     = 5,
  parameter logic [N_REGISTER-1:0] PORT_ID    = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_PORT*N_REGISTER-1:0] req_code,
  input  logic [N_PORT*DATA_WIDTH-1:0] data_in,
  input  logic                         full,
  output logic [N_PORT-1:0]            grant,
  output logic [DATA_WIDTH-1:0]        data_out,
  output logic                         write
);

  localparam int PTR_W = (N_PORT > 1) ? $clog2(N_PORT) : 1;
  localparam logic [PTR_W-1:0] LAST_PORT = PTR_W'(N_PORT - 1);
  localparam logic [N_PORT-1:0] ONE_HOT0 = {{(N_PORT-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_WAIT
  } state_t;

  state_t                r_state;
  logic [PTR_W-1:0]      r_last_ptr;
  logic [N_PORT-1:0]     r_mask;
  logic [N_PORT-1:0]     r_grant;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_write;

  logic [N_PORT-1:0]     w_req;
  logic                  w_found;
  logic [PTR_W-1:0]      w_win;
  logic [N_PORT-1:0]     w_win_oh;
  logic [DATA_WIDTH-1:0] w_win_data;

  always_comb begin
    w_req = '0;
    for (int i = 0; i < N_PORT; i++) begin
      w_req[i] = (req_code[i*N_REGISTER +: N_REGISTER] == PORT_ID) && !r_mask[i];
    end
  end

  // Scan from farthest to nearest offset so the nearest requester after
  // last_ptr is the one left standing; no early exit needed.
  always_comb begin
    int idx;
    idx     = 0;
    w_found = 1'b0;
    w_win   = r_last_ptr;
    for (int off = N_PORT; off >= 1; off--) begin
      idx = int'(r_last_ptr) + off;
      if (idx >= N_PORT) idx = idx - N_PORT;
      if (idx >= N_PORT) idx = idx - N_PORT;
      if (w_req[PTR_W'(idx)]) begin
        w_found = 1'b1;
        w_win   = PTR_W'(idx);
      end
    end
    w_win_oh   = ONE_HOT0 << w_win;
    w_win_data = data_in[w_win*DATA_WIDTH +: DATA_WIDTH];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_last_ptr <= LAST_PORT;
      r_mask     <= '0;
      r_grant    <= '0;
      r_data     <= '0;
      r_write    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found && !full) begin
            r_grant    <= w_win_oh;
            r_data     <= w_win_data;
            r_write    <= 1'b1;
            r_last_ptr <= w_win;
            r_mask     <= w_win_oh;
            r_state    <= S_GRANT;
          end else begin
            r_grant <= '0;
            r_data  <= '0;
            r_write <= 1'b0;
          end
        end
        S_GRANT: begin
          r_grant <= '0;
          r_data  <= '0;
          r_write <= 1'b0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // Winner's code is stale until its FIFO head refreshes; hold it off one cycle.
          r_mask  <= '0;
          r_state <= S_IDLE;
        end
        default: begin
          r_grant <= '0;
          r_data  <= '0;
          r_write <= 1'b0;
          r_mask  <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign grant    = r_grant;
  assign data_out = r_data;
  assign write    = r_write;

endmodule

// File: tb/tb_output_controller.sv
// Scoreboard bench for output_controller (PORT_ID = E): random and directed
// traffic, expected writes predicted by a cycle-level round-robin model.
module tb_output_controller;

  localparam int DW = 8;
  localparam int NR = 3;
  localparam int NP = 5;
  localparam logic [NR-1:0] MY_ID = 3'b001;

  logic               clk = 1'b0;
  logic               rst;
  logic [NP*NR-1:0]   req_code;
  logic [NP*DW-1:0]   data_in;
  logic               full;
  logic [NP-1:0]      grant;
  logic [DW-1:0]      data_out;
  logic               write;

  output_controller #(
    .DATA_WIDTH(DW), .N_REGISTER(NR), .N_PORT(NP), .PORT_ID(MY_ID)
  ) dut (
    .clk(clk), .rst(rst), .req_code(req_code), .data_in(data_in),
    .full(full), .grant(grant), .data_out(data_out), .write(write)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int           cyc;
    logic [NP-1:0] g;
    logic [DW-1:0] d;
  } exp_t;
  exp_t q[$];

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
  endtask

  // Reference model: an output may accept a new flit only every 3 edges; the
  // winner is the next matching port after the previous winner, cyclically.
  int m_ptr;
  int m_next_ok;

  task automatic model_reset();
    m_ptr     = NP - 1;
    m_next_ok = 0;
  endtask

  task automatic model_eval();
    int edge_no;
    edge_no = cyc + 1;
    if (rst || full || edge_no < m_next_ok) return;
    for (int off = 1; off <= NP; off++) begin
      int k;
      logic [NR-1:0] c;
      logic [NP*NR-1:0] rc;
      logic [NP*DW-1:0] di;
      exp_t e;
      k  = (m_ptr + off) % NP;
      rc = req_code;
      di = data_in;
      c  = rc[k*NR +: NR];
      if (c == MY_ID) begin
        e.cyc = edge_no;
        e.g   = NP'(1) << k;
        e.d   = di[k*DW +: DW];
        q.push_back(e);
        m_ptr     = k;
        m_next_ok = edge_no + 3;
        return;
      end
    end
  endtask

  task automatic tick();
    model_eval();
    @(negedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic [NR-1:0] c, input logic [DW-1:0] d);
    req_code[p*NR +: NR] = c;
    data_in[p*DW +: DW]  = d;
  endtask

  task automatic clear_all();
    req_code = '1;
    data_in  = '0;
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  int last_wr = -100;
  always @(negedge clk) begin
    check("grant_onehot0", 32'($onehot0(grant)), 32'd1);
    check("write_eq_any_grant", 32'(write), 32'(|grant));
    if (rst) begin
      last_wr = -100;
    end else if (write) begin
      if (q.size() == 0 || q[0].cyc != cyc) begin
        check("unexpected_write", 32'(write), 32'd0);
        if (q.size() > 0 && q[0].cyc < cyc) void'(q.pop_front());
      end else begin
        exp_t e;
        e = q.pop_front();
        check("grant", 32'(grant), 32'(e.g));
        check("data_out", 32'(data_out), 32'(e.d));
        check("write_spacing_ge3", 32'(cyc - last_wr >= 3), 32'd1);
        last_wr = cyc;
      end
    end else if (q.size() > 0 && q[0].cyc <= cyc) begin
      check("missing_write", 32'(write), 32'd1);
      void'(q.pop_front());
    end
  end

  initial begin
    rst  = 1'b1;
    full = 1'b0;
    clear_all();
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("reset_grant", 32'(grant), 32'd0);
    check("reset_write", 32'(write), 32'd0);
    check("reset_data", 32'(data_out), 32'd0);
    rst = 1'b0;

    // Single request from port W
    set_port(2, 3'b001, 8'hA5);
    tick();
    clear_all();
    repeat (3) tick();

    // Round-robin among L, W, S
    set_port(0, 3'b001, 8'h11);
    set_port(2, 3'b001, 8'h22);
    set_port(4, 3'b001, 8'h44);
    repeat (12) tick();
    clear_all();
    repeat (3) tick();

    // Backpressure on port N
    set_port(3, 3'b001, 8'h3C);
    full = 1'b1;
    repeat (4) tick();
    full = 1'b0;
    tick();
    clear_all();
    repeat (3) tick();

    // Codes that never match this output
    set_port(0, 3'b000, 8'h01);
    set_port(1, 3'b011, 8'h02);
    set_port(2, 3'b111, 8'h03);
    set_port(3, 3'b101, 8'h04);
    set_port(4, 3'b110, 8'h05);
    repeat (6) tick();
    clear_all();

    // Port E holds its request through GRANT and WAIT
    set_port(1, 3'b001, 8'h5A);
    repeat (9) tick();
    clear_all();
    repeat (3) tick();

    // Asynchronous reset in the middle of a GRANT cycle
    set_port(1, 3'b001, 8'hB1);
    set_port(3, 3'b001, 8'hB3);
    tick();
    rst = 1'b1;
    #1;
    check("async_rst_grant", 32'(grant), 32'd0);
    check("async_rst_write", 32'(write), 32'd0);
    check("async_rst_data", 32'(data_out), 32'd0);
    model_reset();
    q.delete();
    tick();
    rst = 1'b0;
    repeat (4) tick();
    clear_all();
    repeat (3) tick();

    // Random traffic
    for (int t = 0; t < 400; t++) begin
      for (int p = 0; p < NP; p++) begin
        logic [NR-1:0] c;
        c = ($urandom_range(0, 1) == 1) ? MY_ID : NR'($urandom_range(0, 7));
        set_port(p, c, DW'($urandom));
      end
      full = ($urandom_range(0, 4) == 0);
      repeat ($urandom_range(1, 3)) tick();
    end
    full = 1'b0;
    clear_all();
    repeat (5) tick();
    check("queue_drained", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/output_controller.md
Name: output_controller

Overview:
- One instance per router output port (L/E/W/N/S); it is the consumer end of the input-controller request/grant handshake.
- Watches the 3-bit route request code and data flit from all five input controllers and arbitrates round-robin among those requesting this port.
- Issues a one-cycle grant to the winner, which pops that input FIFO, and writes the winner's flit into the downstream FIFO/link when it is not full.
- Single-flit packets only: every flit is arbitrated independently.

Parameters:
- DATA_WIDTH, 8: flit width.
- N_REGISTER, 3: width of each route request code.
- N_PORT, 5: number of input controllers; index 0=L, 1=E, 2=W, 3=N, 4=S.
- PORT_ID, 3'b000: code of this output (000 L, 001 E, 010 W, 011 N, 100 S). Legal values 0..4 only.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req_code  input  N_PORT*N_REGISTER  route codes; slice i = [i*N_REGISTER +: N_REGISTER] from input controller i; 3'b111 = no request.
- data_in  input  N_PORT*DATA_WIDTH  flits; slice i = [i*DATA_WIDTH +: DATA_WIDTH].
- full  input  1  downstream FIFO full.
- grant  output  N_PORT  one-hot grant to input controllers (registered).
- data_out  output  DATA_WIDTH  flit to downstream (registered).
- write  output  1  downstream write strobe (registered).

Behaviour:
- Request vector: req[i] = (req_code slice i == PORT_ID) and not masked. Codes 101, 110 and 111 never match.
- Reset (async, any state, including mid-grant):
  - grant = 0, data_out = 0, write = 0.
  - state = IDLE, last_ptr = N_PORT-1 (first priority goes to port 0), mask = 0.
- FSM states: IDLE, GRANT, WAIT.
- IDLE:
  - If any req and full==0, at the clock edge:
    - winner k = first index with req set, searching last_ptr+1, last_ptr+2, … modulo N_PORT.
    - grant <= one-hot(k), data_out <= data_in slice k, write <= 1, last_ptr <= k, mask <= one-hot(k), state <= GRANT.
  - Otherwise grant, write and data_out stay 0 and state stays IDLE.
  - full==1 blocks all grants; requests remain pending and the pointer does not move.
- GRANT: lasts exactly one cycle, with grant, write and data_out valid.
  - The input controller's read is high in this cycle, and the downstream FIFO samples write/data_out at the edge ending the cycle.
  - Next edge: grant <= 0, write <= 0, data_out <= 0, state <= WAIT.
- WAIT: lasts exactly one cycle.
  - Port k stays masked because its request code is stale while its FIFO head refreshes.
  - Requests from other ports are not arbitrated in this cycle.
  - Next edge: mask <= 0, state <= IDLE.
- Throughput:
  - At most one flit per 3 cycles per output.
  - Latency from request visible in IDLE to write high is 1 cycle.
- full rising during GRANT does not cancel the write already issued; the upstream check is made only in IDLE.
- A request that drops before the IDLE edge is not granted. No request is ever granted twice from a single sample.
- Pointer wrap: last_ptr = 4 searches from 0. Only the winner updates the pointer.
- If several inputs request simultaneously, exactly one is granted per arbitration.
- grant is always one-hot or zero; write == |grant at all times.

Test Plan:
- Reset check: assert rst mid-GRANT with PORT_ID=1 -> grant=00000, write=0, data_out=00 immediately, without waiting for a clock edge. After release, the first grant goes to the lowest-index requester.
- Single request: PORT_ID=1, port 2 code 001, data 8'hA5, full=0 -> next cycle grant=00100, write=1, data_out=A5 for one cycle. Then one WAIT cycle, then back to IDLE.
- Round-robin: ports 0, 2 and 4 request continuously -> grants in order 00001, 00100, 10000, 00001, each 3 cycles apart.
- Backpressure: port 3 requests with full=1 for 4 cycles -> grant and write stay 0. When full drops, the next cycle gives grant=01000 and write=1.
- Non-matching codes: PORT_ID=0, all ports present 001, 011, 111 and 101 -> no grant ever.
- Stale mask: port 1 holds code 000 through GRANT and WAIT -> exactly one write per 3-cycle window, never in back-to-back cycles.
